// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - MEM-stage data port responder with wait states, byte lanes and load extension
// Optional misaligned/illegal access trapping is enabled with `define MISALIGN_TRAP_EN.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_mode,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t        state, state_nxt;
    logic [3:0]    wait_cnt, wait_cnt_nxt;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    mode_q;
    logic          uns_q;
    logic [31:0]   mem [DEPTH_WORDS];

    logic [1:0]    ld_sz, st_sz, acc_sz, lane;
    logic          illegal, fault;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wr_data, rd_shift, ld_data;

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt = S_ACCESS;
                    end else begin
                        state_nxt    = S_WAIT;
                        wait_cnt_nxt = 4'(WAIT_STATES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) state_nxt = S_ACCESS;
                else                  wait_cnt_nxt = wait_cnt - 4'd1;
            end
            S_ACCESS: state_nxt = S_RESP;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            mode_q   <= 4'd0;
            uns_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (req_valid && req_ready) begin
                addr_q  <= req_addr[AW+1:0];
                wdata_q <= req_wdata;
                mode_q  <= req_mode;
                uns_q   <= req_unsigned;
            end
        end
    end

    // Access decode works on the latched request; only one of ld_sz/st_sz is nonzero when legal.
    assign ld_sz   = mode_q[3:2];
    assign st_sz   = mode_q[1:0];
    assign acc_sz  = ld_sz | st_sz;
    assign illegal = (mode_q == 4'd0) || ((ld_sz != 2'd0) && (st_sz != 2'd0));
    assign idx     = addr_q[AW+1:2];

`ifdef MISALIGN_TRAP_EN
    assign fault = illegal || ((acc_sz == 2'b10) && addr_q[0])
                           || ((acc_sz == 2'b11) && (addr_q[1:0] != 2'b00));
    assign lane  = addr_q[1:0];
`else
    assign fault = illegal;
    assign lane  = (acc_sz == 2'b11) ? 2'b00 :
                   (acc_sz == 2'b10) ? {addr_q[1], 1'b0} : addr_q[1:0];
`endif

    always_comb begin
        be      = 4'b0000;
        wr_data = wdata_q;
        case (acc_sz)
            2'b01: begin be = 4'b0001 << lane; wr_data = {4{wdata_q[7:0]}};  end
            2'b10: begin be = 4'b0011 << lane; wr_data = {2{wdata_q[15:0]}}; end
            2'b11: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if ((state == S_ACCESS) && (st_sz != 2'd0) && !fault) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign rd_shift = mem[idx] >> {lane, 3'b000};

    always_comb begin
        ld_data = 32'd0;
        case (ld_sz)
            2'b01: ld_data = {{24{rd_shift[7] & ~uns_q}}, rd_shift[7:0]};
            2'b10: ld_data = {{16{rd_shift[15] & ~uns_q}}, rd_shift[15:0]};
            2'b11: ld_data = mem[idx];
            default: ld_data = 32'd0;
        endcase
        if (fault) ld_data = 32'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata <= 32'd0;
        end else if (state == S_ACCESS) begin
            rsp_rdata <= ld_data;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_err <= 1'b0;
        end else if (state == S_ACCESS) begin
            rsp_err <= fault;
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized self-checking bench for data_mem_responder against a byte-array model
module tb_data_mem_responder;
    localparam int DEPTH = 256;
    localparam int W     = 1;
    localparam int NB    = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_mode = 4'd0;
    logic        req_unsigned = 1'b0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [7:0] mm [NB];

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_mode(req_mode), .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: memory is a flat little-endian byte array addressed modulo its size.
    function automatic void model(input logic [3:0] mode, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic uns,
                                  output logic [31:0] rd, output logic err);
        int ls, ss, n, a;
        bit ill, mis;
        logic [31:0] v;
        ls  = int'(mode[3:2]);
        ss  = int'(mode[1:0]);
        ill = (mode == 4'd0) || (ls != 0 && ss != 0);
        rd  = 32'd0;
        err = 1'b0;
        if (ill) begin
`ifdef MISALIGN_TRAP_EN
            err = 1'b1;
`endif
            return;
        end
        n   = ((ls | ss) == 3) ? 4 : (ls | ss);
        a   = int'(addr % NB);
        mis = (a % n) != 0;
`ifdef MISALIGN_TRAP_EN
        if (mis) begin
            err = 1'b1;
            return;
        end
`else
        a = a - (a % n);
`endif
        if (ss != 0) begin
            for (int i = 0; i < n; i++) mm[a + i] = wdata[8*i +: 8];
            return;
        end
        v = 32'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mm[a + i];
        if (n < 4 && !uns && v[8*n - 1]) begin
            for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        end
        rd = v;
    endfunction

    task automatic do_req(input logic [3:0] mode, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic uns, output logic [31:0] rd, output logic err, output int lat);
        int g;
        @(negedge clk);
        req_valid = 1'b1; req_mode = mode; req_addr = addr; req_wdata = wdata; req_unsigned = uns;
        g = 0;
        while (!req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 50);
        rd  = rsp_rdata;
        err = rsp_err;
    endtask

    task automatic txn(input string tag, input logic [3:0] mode, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic uns, output logic [31:0] rd);
        logic [31:0] erd;
        logic        eerr, err;
        int          lat;
        do_req(mode, addr, wdata, uns, rd, err, lat);
        model(mode, addr, wdata, uns, erd, eerr);
        check({tag, "_rdata"}, rd, erd);
        check({tag, "_err"}, {31'd0, err}, {31'd0, eerr});
        check({tag, "_lat"}, lat, W + 2);
        @(negedge clk);
        check({tag, "_pulse"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    logic [31:0] rd, rd2;
    logic [3:0]  modes [9] = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b1000,
                               4'b1100, 4'b0000, 4'b1111, 4'b0110};
    int          rsp_k [$];
    logic [31:0] rsp_d [$];
    bit          rdy_k [int];
    int          cnt;

    initial begin
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] d, e; int l;
            d = $urandom;
            do_req(4'b0011, 32'(i * 4), d, 1'b0, rd, e, l);
            model(4'b0011, 32'(i * 4), d, 1'b0, rd, e);
        end

        txn("sw_deadbeef", 4'b0011, 32'h10, 32'hDEADBEEF, 1'b0, rd);
        txn("lw_deadbeef", 4'b1100, 32'h10, 32'h0, 1'b0, rd);
        check("lw_deadbeef_const", rd, 32'hDEADBEEF);

        txn("sb_80", 4'b0001, 32'h21, 32'h00000080, 1'b0, rd);
        txn("lb_80", 4'b0100, 32'h21, 32'h0, 1'b0, rd);
        check("lb_80_const", rd, 32'hFFFFFF80);
        txn("lbu_80", 4'b0100, 32'h21, 32'h0, 1'b1, rd);
        check("lbu_80_const", rd, 32'h00000080);
        txn("lw_20", 4'b1100, 32'h20, 32'h0, 1'b0, rd);
        check("lw_20_byte1", {24'd0, rd[15:8]}, 32'h80);

        txn("sh_8001", 4'b0010, 32'h32, 32'h00008001, 1'b0, rd);
        txn("lh_8001", 4'b1000, 32'h32, 32'h0, 1'b0, rd);
        check("lh_8001_const", rd, 32'hFFFF8001);
        txn("lhu_8001", 4'b1000, 32'h32, 32'h0, 1'b1, rd);
        check("lhu_8001_const", rd, 32'h00008001);

        txn("sw_wrap", 4'b0011, 32'h400, 32'hCAFEF00D, 1'b0, rd);
        txn("lw_wrap", 4'b1100, 32'h000, 32'h0, 1'b0, rd);
        check("lw_wrap_const", rd, 32'hCAFEF00D);

        txn("sw_pre", 4'b0011, 32'h10, 32'h11111111, 1'b0, rd);
        txn("sw_mis", 4'b0011, 32'h13, 32'h22222222, 1'b0, rd);
        txn("lw_mis", 4'b1100, 32'h10, 32'h0, 1'b0, rd);
`ifdef MISALIGN_TRAP_EN
        check("lw_mis_const", rd, 32'h11111111);
`else
        check("lw_mis_const", rd, 32'h22222222);
`endif
        txn("ill_zero", 4'b0000, 32'h10, 32'h0, 1'b0, rd);
        txn("ill_both", 4'b1111, 32'h10, 32'h55555555, 1'b0, rd);
        txn("lw_after_ill", 4'b1100, 32'h10, 32'h0, 1'b0, rd);

        for (int i = 0; i < 200; i++) begin
            logic [3:0] m;
            m = modes[$urandom_range(8, 0)];
            txn("rand", m, $urandom, $urandom, 1'($urandom_range(1, 0)), rd);
        end

        // Valid held high across a whole transaction and into the following IDLE.
        @(negedge clk);
        req_valid = 1'b1; req_mode = 4'b1100; req_addr = 32'h10; req_unsigned = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 2 * W + 7; k++) begin
            @(negedge clk);
            rdy_k[k] = req_ready;
            if (rsp_valid) begin
                rsp_k.push_back(k);
                rsp_d.push_back(rsp_rdata);
            end
            if (k == W + 4) req_valid = 1'b0;
        end
        model(4'b1100, 32'h10, 32'h0, 1'b0, rd, rd2[0]);
        check("held_rsp_count", rsp_k.size(), 2);
        if (rsp_k.size() == 2) begin
            check("held_rsp1_cycle", rsp_k[0], W + 2);
            check("held_rsp2_cycle", rsp_k[1], 2 * W + 5);
            check("held_rsp1_data", rsp_d[0], rd);
            check("held_rsp2_data", rsp_d[1], rd);
        end
        check("held_ready_busy", {31'd0, rdy_k[1]}, 32'd0);
        check("held_ready_idle", {31'd0, rdy_k[W + 3]}, 32'd1);
        check("held_ready_second", {31'd0, rdy_k[W + 4]}, 32'd0);

        // Reset during WAIT of a store: no response and no write.
        txn("sw_old", 4'b0011, 32'h50, 32'hAAAA5555, 1'b0, rd);
        @(negedge clk);
        req_valid = 1'b1; req_mode = 4'b0011; req_addr = 32'h50; req_wdata = 32'h12345678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ready", {31'd0, req_ready}, 32'd1);
        check("midrst_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        check("midrst_no_rsp", cnt, 0);
        txn("lw_old", 4'b1100, 32'h50, 32'h0, 1'b0, rd);
        check("lw_old_const", rd, 32'hAAAA5555);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
